time_display_scanner: RTL
=========================

# time_display_scanner

Multiplexed 8-digit seven-segment driver that sits directly downstream of the time-keeping block and consumes its 32-bit packed BCD time word (eight 4-bit digits). Each frame it takes a snapshot of the word and scans the digits one at a time onto shared segment lines with per-digit common enables. It supports decimal points and per-digit blinking, which the setting modes use. All outputs are registered and go straight to the board pins.

## Interface
- SCAN_DIV, 10000: CLK cycles each digit stays enabled; must be ≥2. The counter width is $clog2(SCAN_DIV).
- BLINK_FRAMES, 64: frames per blink half-period; must be ≥1.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DATA  in  32  packed BCD word. Digit i is DATA[4i+3:4i]; digit 0 is the rightmost.
- DP_MASK  in  8  bit i lights the decimal point of digit i.
- BLINK_MASK  in  8  bit i makes digit i blink.
- SEG  out  8  segment pattern {dp,g,f,e,d,c,b,a}; active-high.
- COM  out  8  digit enables; active-low; at most one bit low at a time.
- FRAME_TICK  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Its terminal count (TC) advances the digit index: 0→1→…→7→0.
- Snapshot:
  - On the TC where the index goes 7→0, latch DATA, DP_MASK and BLINK_MASK, and pulse FRAME_TICK.
  - Input changes between snapshots have no visible effect. There is no tearing within a frame.
- Decode, per digit, from the snapshot nibble:
  - Nibbles 0-9 use the standard patterns: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, g..a).
  - Nibbles A-F display blank (g..a = 0).
  - SEG[7] = the snapshot DP_MASK bit for that digit.
- Blink:
  - A frame counter counts 0..BLINK_FRAMES-1; the blink phase toggles when it wraps.
  - When the phase is 1 and the snapshot BLINK_MASK bit for the current digit is set, SEG = 00 (including dp). COM is still asserted for that digit.
  - Phase 0 shows every digit normally.
- Reset values (applied asynchronously):
  - Prescaler = 0, index = 7, snapshots = 0, frame counter = 0, phase = 0.
  - SEG = 8'h00, COM = 8'hFF, FRAME_TICK = 0.
  - Because the index starts at 7, the first TC takes a snapshot and shows digit 0. No stale data is ever displayed.
- If RESET asserts mid-frame, the outputs take their reset values immediately and the scan restarts from the post-reset sequence.

## Timing
- SEG, COM and FRAME_TICK are all registered. They update on the same CLK edge as the index advance, with no extra latency.
- After RESET deasserts, the first TC occurs at the SCAN_DIV-th rising edge. On that edge FRAME_TICK = 1, COM = FE, and SEG shows DATA[3:0] as sampled at that edge.
- Each digit is enabled for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- FRAME_TICK is high for exactly one cycle per frame.
- The blink phase changes only on frame boundaries, so a digit never blinks partway through its slot.
- DATA is sampled only on the snapshot edge. Upstream need not hold it stable at other times.

## Structure
- A shared package/header holds:
  - the digit count (8);
  - the ten segment pattern constants;
  - the blank pattern;
  - the COM-off value 8'hFF.
- One natural sub-module: bcd_to_seg, a combinational decoder (4-bit nibble → 7-bit pattern, blank for A-F). It is instantiated once, on the muxed nibble.
- The top level holds:
  - the prescaler, index, frame and phase counters;
  - the snapshot registers;
  - the output registers.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_FRAMES = 2.
- Reset: hold RESET for 5 cycles, then release. Required: COM = FF and SEG = 00 throughout reset and for 3 edges after release. On the 4th edge, FRAME_TICK = 1, COM = FE and SEG matches DATA[3:0].
- Scan: DATA = 32'h12345678, masks 0. Required sequence of COM/SEG pairs, 4 cycles each: FE/7F, FD/07, FB/7D, F7/6D, EF/66, DF/4F, BF/5B, 7F/06, then wrap to FE with a FRAME_TICK pulse.
- Snapshot isolation: change DATA to 32'h99999999 while digit 3 is showing. Required: the rest of the frame still shows the old digits; 6F appears only after the next FRAME_TICK.
- Decode edges: DATA = 32'hFEDCBA90, DP_MASK = 8'h01. Required: digit 0 SEG = BF, digit 1 SEG = 6F, digits 2-7 SEG = 00.
- Blink: BLINK_MASK = 8'h03, DATA = 32'h00000011. Required: in frames 0-1, digits 0 and 1 show 06. In frames 2-3, those digits show SEG = 00 with COM still asserted, while digits 2-7 are unaffected. Frames 4-5 are visible again.
- Async reset mid-frame: assert RESET between clock edges while digit 5 is showing. Required: COM = FF and SEG = 00 before the next edge, and the post-release sequence is identical to the Reset scenario.

Source files
------------

// File: rtl/time_display_scanner_pkg.sv
// Shared constants for the time display scanner.
// Holds the digit count, the seven-segment patterns (g..a, active-high),
// the blank pattern and the idle values driven onto COM and SEG.
package time_display_scanner_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Segment patterns for decimal digits, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Full 8-bit SEG value with everything dark, including dp
    localparam logic [7:0] SEG_OFF = 8'h00;

    // COM is active-low: all ones means no digit enabled
    localparam logic [7:0] COM_OFF = 8'hFF;

endpackage

// File: rtl/time_display_scanner_bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to seven-segment decoder.
// Ports:
//   nibble  - 4-bit BCD digit value
//   pattern - {g,f,e,d,c,b,a} active-high; blank for A-F
module bcd_to_seg
    import time_display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Decode one digit; non-decimal codes show nothing
    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'd0:    pattern = SEG_DIGIT_0;
            4'd1:    pattern = SEG_DIGIT_1;
            4'd2:    pattern = SEG_DIGIT_2;
            4'd3:    pattern = SEG_DIGIT_3;
            4'd4:    pattern = SEG_DIGIT_4;
            4'd5:    pattern = SEG_DIGIT_5;
            4'd6:    pattern = SEG_DIGIT_6;
            4'd7:    pattern = SEG_DIGIT_7;
            4'd8:    pattern = SEG_DIGIT_8;
            4'd9:    pattern = SEG_DIGIT_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display_scanner.sv
// time_display_scanner: multiplexed 8-digit seven-segment driver.
// Snapshots a packed BCD time word once per frame and scans its digits
// onto shared segment lines, with decimal points and per-digit blinking.
// Ports:
//   CLK, RESET  - clock, asynchronous active-high reset
//   DATA        - 32-bit packed BCD, digit i = DATA[4i+3:4i], digit 0 rightmost
//   DP_MASK     - per-digit decimal point enable
//   BLINK_MASK  - per-digit blink enable
//   SEG         - {dp,g,f,e,d,c,b,a}, active-high, registered
//   COM         - digit enables, active-low, registered
//   FRAME_TICK  - one-cycle pulse on the edge a new snapshot is taken
module time_display_scanner
    import time_display_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 10000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP_MASK,
    input  logic [7:0]  BLINK_MASK,
    output logic [7:0]  SEG,
    output logic [7:0]  COM,
    output logic        FRAME_TICK
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       dp_q, dp_d;
    logic [7:0]       blink_q, blink_d;
    logic [FR_W-1:0]  frame_q, frame_d;
    logic             phase_q, phase_d;
    logic             started_q, started_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       com_q, com_d;
    logic             tick_q, tick_d;

    logic             tc_s;
    logic             wrap_s;
    logic [3:0]       nibble_s;
    logic [6:0]       pattern_s;
    logic             show_dp_s;
    logic             blank_s;

    // Prescaler, digit index, snapshot and blink-phase next-state logic
    always_comb begin
        tc_s   = (presc_q == CNT_LAST);
        wrap_s = tc_s && (idx_q == IDX_LAST);

        if (tc_s) begin
            presc_d = {CNT_W{1'b0}};
            // Eight digits fill the index width exactly, so 7 rolls to 0
            idx_d   = idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + CNT_W'(1);
            idx_d   = idx_q;
        end

        if (wrap_s) begin
            data_d  = DATA;
            dp_d    = DP_MASK;
            blink_d = BLINK_MASK;
        end else begin
            data_d  = data_q;
            dp_d    = dp_q;
            blink_d = blink_q;
        end

        // The first snapshot after reset opens frame 0 rather than ending a
        // frame, so it must not advance the blink frame counter.
        if (wrap_s && started_q) begin
            if (frame_q == FR_LAST) begin
                frame_d = {FR_W{1'b0}};
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FR_W'(1);
                phase_d = phase_q;
            end
        end else begin
            frame_d = frame_q;
            phase_d = phase_q;
        end

        if (wrap_s) begin
            started_d = 1'b1;
        end else begin
            started_d = started_q;
        end
    end

    // Digit mux on the values that become current at this edge, so the
    // outputs change together with the index with no added latency
    always_comb begin
        nibble_s  = data_d[{idx_d, 2'b00} +: 4];
        show_dp_s = dp_d[idx_d];
        blank_s   = phase_d & blink_d[idx_d];
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble  (nibble_s),
        .pattern (pattern_s)
    );

    // Output next-state: refresh only when the digit slot changes
    always_comb begin
        tick_d = wrap_s;
        if (tc_s) begin
            com_d = ~(8'h01 << idx_d);
            if (blank_s) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = {show_dp_s, pattern_s};
            end
        end else begin
            com_d = com_q;
            seg_d = seg_q;
        end
    end

    // State and output registers; index starts at the last digit so the
    // first terminal count takes a snapshot and shows digit 0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_q   <= {CNT_W{1'b0}};
            idx_q     <= IDX_LAST;
            data_q    <= 32'h0000_0000;
            dp_q      <= 8'h00;
            blink_q   <= 8'h00;
            frame_q   <= {FR_W{1'b0}};
            phase_q   <= 1'b0;
            started_q <= 1'b0;
            seg_q     <= SEG_OFF;
            com_q     <= COM_OFF;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            dp_q      <= dp_d;
            blink_q   <= blink_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            started_q <= started_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
            tick_q    <= tick_d;
        end
    end

    assign SEG        = seg_q;
    assign COM        = com_q;
    assign FRAME_TICK = tick_q;

endmodule
